// File: rtl/eth_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eth_pkg                                                              |
// | Shared Ethernet constants and the tx arbiter state encoding.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package eth_pkg;

  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam int          MAC_W          = 48;
  localparam int          ETHERTYPE_W    = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/eth_tx_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eth_tx_arbiter_if                                                    |
// | Per-source AXIS inputs with sideband, plus the single merged output. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface eth_tx_arbiter_if
  import eth_pkg::*;
#(
  parameter int NUM_SOURCES = 2,
  parameter int AXIS_BYTES  = 4
);
  localparam int SRC_W = $clog2(NUM_SOURCES);

  logic [NUM_SOURCES-1:0]              axis_i_tready;
  logic [NUM_SOURCES-1:0]              axis_i_tvalid;
  logic [NUM_SOURCES-1:0]              axis_i_tlast;
  logic [NUM_SOURCES*AXIS_BYTES-1:0]   axis_i_tkeep;
  logic [NUM_SOURCES*AXIS_BYTES*8-1:0] axis_i_tdata;
  logic [NUM_SOURCES*MAC_W-1:0]        axis_i_dst_mac;
  logic [NUM_SOURCES*ETHERTYPE_W-1:0]  axis_i_ethertype;

  logic                                axis_o_tready;
  logic                                axis_o_tvalid;
  logic                                axis_o_tlast;
  logic [AXIS_BYTES-1:0]               axis_o_tkeep;
  logic [AXIS_BYTES*8-1:0]             axis_o_tdata;
  logic [MAC_W-1:0]                    axis_o_dst_mac;
  logic [ETHERTYPE_W-1:0]              axis_o_ethertype;
  logic [SRC_W-1:0]                    axis_o_src;

  // Arbiter-side view
  modport slave (
    output axis_i_tready,
    input  axis_i_tvalid, axis_i_tlast, axis_i_tkeep, axis_i_tdata,
    input  axis_i_dst_mac, axis_i_ethertype,
    input  axis_o_tready,
    output axis_o_tvalid, axis_o_tlast, axis_o_tkeep, axis_o_tdata,
    output axis_o_dst_mac, axis_o_ethertype, axis_o_src
  );

  // Environment-side view (sources and downstream framer)
  modport master (
    input  axis_i_tready,
    output axis_i_tvalid, axis_i_tlast, axis_i_tkeep, axis_i_tdata,
    output axis_i_dst_mac, axis_i_ethertype,
    output axis_o_tready,
    input  axis_o_tvalid, axis_o_tlast, axis_o_tkeep, axis_o_tdata,
    input  axis_o_dst_mac, axis_o_ethertype, axis_o_src
  );

endinterface
`default_nettype wire

// File: rtl/eth_tx_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter                                                           |
// | Combinational round-robin pick, searching from last+1 upward.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter  int NUM   = 2,
  localparam int IDX_W = $clog2(NUM)
) (
  input  logic [NUM-1:0]   req,
  input  logic [IDX_W-1:0] last,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  int w_pos;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = last;
    w_pos     = 0;
    for (int k = NUM; k >= 1; k--) begin
      w_pos = (int'(last) + k) % NUM;
      if (req[IDX_W'(w_pos)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(w_pos);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eth_tx_arbiter                                                       |
// | Packet-level round-robin merge of AXIS sources with MAC/type sideband.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int AXIS_BYTES  = 4,
  parameter int NUM_SOURCES = 2
) (
  input  logic             clk,
  input  logic             sresetn,
  eth_tx_arbiter_if.slave  bus
);

  localparam int               SRC_W      = $clog2(NUM_SOURCES);
  localparam int               DATA_W     = AXIS_BYTES * 8;
  localparam logic [SRC_W-1:0] C_LAST_SRC = SRC_W'(NUM_SOURCES - 1);

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [SRC_W-1:0]       r_grant;
  logic [SRC_W-1:0]       r_last_grant;
  logic [SRC_W-1:0]       w_gnt_idx;
  logic                   w_gnt_valid;
  logic                   w_in_ready;
  logic                   w_in_hs;
  logic [NUM_SOURCES-1:0] w_tready;

  logic                   w_sel_tvalid;
  logic                   w_sel_tlast;
  logic [AXIS_BYTES-1:0]  w_sel_tkeep;
  logic [DATA_W-1:0]      w_sel_tdata;
  logic [MAC_W-1:0]       w_sel_mac;
  logic [ETHERTYPE_W-1:0] w_sel_etype;

  logic                   r_o_tvalid;
  logic                   r_o_tlast;
  logic [AXIS_BYTES-1:0]  r_o_tkeep;
  logic [DATA_W-1:0]      r_o_tdata;
  logic [MAC_W-1:0]       r_o_mac;
  logic [ETHERTYPE_W-1:0] r_o_etype;
  logic [SRC_W-1:0]       r_o_src;

  rr_arbiter #(.NUM(NUM_SOURCES)) u_rr (
    .req       (bus.axis_i_tvalid),
    .last      (r_last_grant),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  assign w_sel_tvalid = bus.axis_i_tvalid[r_grant];
  assign w_sel_tlast  = bus.axis_i_tlast[r_grant];
  assign w_sel_tkeep  = bus.axis_i_tkeep[int'(r_grant)*AXIS_BYTES +: AXIS_BYTES];
  assign w_sel_tdata  = bus.axis_i_tdata[int'(r_grant)*DATA_W +: DATA_W];
  assign w_sel_mac    = bus.axis_i_dst_mac[int'(r_grant)*MAC_W +: MAC_W];
  assign w_sel_etype  = bus.axis_i_ethertype[int'(r_grant)*ETHERTYPE_W +: ETHERTYPE_W];

  assign w_in_ready = !r_o_tvalid || bus.axis_o_tready;
  assign w_in_hs    = (r_state == ST_PASS) && w_in_ready && w_sel_tvalid;

  always_ff @(posedge clk) begin
    if (!sresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_gnt_valid)            w_state_nxt = ST_PASS;
      ST_PASS: if (w_in_hs && w_sel_tlast) w_state_nxt = ST_IDLE;
      default:                             w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tready = '0;
    if (r_state == ST_PASS) w_tready[r_grant] = w_in_ready;
  end

  assign bus.axis_i_tready = w_tready;

  // Grant is held for the whole packet, even across source tvalid gaps.
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      r_grant      <= '0;
      r_last_grant <= C_LAST_SRC;
    end else if (r_state == ST_IDLE && w_gnt_valid) begin
      r_grant      <= w_gnt_idx;
      r_last_grant <= w_gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      r_o_tvalid <= 1'b0;
      r_o_tlast  <= 1'b0;
      r_o_tkeep  <= '0;
      r_o_tdata  <= '0;
      r_o_mac    <= '0;
      r_o_etype  <= '0;
      r_o_src    <= '0;
    end else if (w_in_hs) begin
      r_o_tvalid <= 1'b1;
      r_o_tlast  <= w_sel_tlast;
      r_o_tkeep  <= w_sel_tkeep;
      r_o_tdata  <= w_sel_tdata;
      r_o_mac    <= w_sel_mac;
      r_o_etype  <= w_sel_etype;
      r_o_src    <= r_grant;
    end else if (bus.axis_o_tready) begin
      r_o_tvalid <= 1'b0;
    end
  end

  assign bus.axis_o_tvalid    = r_o_tvalid;
  assign bus.axis_o_tlast     = r_o_tlast;
  assign bus.axis_o_tkeep     = r_o_tkeep;
  assign bus.axis_o_tdata     = r_o_tdata;
  assign bus.axis_o_dst_mac   = r_o_mac;
  assign bus.axis_o_ethertype = r_o_etype;
  assign bus.axis_o_src       = r_o_src;

endmodule
`default_nettype wire
